// File: rtl/demux_32_bit_1x2_buf.sv
// 1-to-2 word demultiplexer with a small FIFO per destination channel.
// control picks the channel for each accepted word; each channel drains independently.
module demux_32_bit_1x2_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             control,
  output logic             in_ready,
  output logic [31:0]      out_data1,
  output logic [31:0]      out_data2,
  output logic             out_valid1,
  output logic             out_valid2,
  input  logic             out_ready1,
  input  logic             out_ready2,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      mem_q  [2][DEPTH];
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    wptr_d [2];
  logic [AW-1:0]    rptr_q [2];
  logic [AW-1:0]    rptr_d [2];
  logic [AW:0]      occ_q  [2];
  logic [AW:0]      occ_d  [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];

  logic [1:0] full;
  logic [1:0] nonempty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_rdy;

  assign out_rdy = {out_ready2, out_ready1};

  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      full[k]     = (occ_q[k] == OCC_FULL);
      nonempty[k] = (occ_q[k] != '0);
    end
  end

  // Readiness looks only at the selected channel's own fill level, never at the
  // consumers, so a pop freeing a full channel is seen one cycle later.
  assign in_ready = ~full[control];

  always_comb begin
    push    = '0;
    push[0] = in_valid & in_ready & ~control;
    push[1] = in_valid & in_ready &  control;
    pop     = nonempty & out_rdy;
  end

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      wptr_d[k] = wptr_q[k];
      rptr_d[k] = rptr_q[k];
      occ_d[k]  = occ_q[k];
      cnt_d[k]  = cnt_q[k];
      if (push[k]) begin
        wptr_d[k] = wptr_q[k] + PTR_ONE;
        cnt_d[k]  = cnt_q[k] + CNT_ONE;
      end
      if (pop[k]) begin
        rptr_d[k] = rptr_q[k] + PTR_ONE;
      end
      case ({push[k], pop[k]})
        2'b10:   occ_d[k] = occ_q[k] + OCC_ONE;
        2'b01:   occ_d[k] = occ_q[k] - OCC_ONE;
        default: occ_d[k] = occ_q[k];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 2; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        occ_q[k]  <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        occ_q[k]  <= occ_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  // Storage is not reset: stale words are unreachable once occupancy is cleared,
  // and the output mux forces zero whenever the channel is empty.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem_q[k][wptr_q[k]] <= in_data;
      end
    end
  end

  assign out_valid1 = nonempty[0];
  assign out_valid2 = nonempty[1];
  assign out_data1  = nonempty[0] ? mem_q[0][rptr_q[0]] : '0;
  assign out_data2  = nonempty[1] ? mem_q[1][rptr_q[1]] : '0;
  assign count1     = cnt_q[0];
  assign count2     = cnt_q[1];

endmodule
